// File: rtl/gru_pkg.sv
// Shared encodings and layer-size constants for the GRU layer sequencer.
package gru_pkg;

    typedef enum logic [2:0] {
        OP_BIAS = 3'd0,
        OP_IN   = 3'd1,
        OP_REC  = 3'd2,
        OP_ACT  = 3'd3,
        OP_UPD  = 3'd4
    } op_kind_e;

    typedef enum logic [1:0] {
        GATE_Z = 2'd0,
        GATE_R = 2'd1,
        GATE_H = 2'd2
    } gate_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIAS = 3'd1,
        S_IN   = 3'd2,
        S_REC  = 3'd3,
        S_ACT  = 3'd4,
        S_UPD  = 3'd5,
        S_FIN  = 3'd6
    } state_e;

    // Counter/address commands issued by the FSM to the address generator.
    typedef enum logic [2:0] {
        AG_HOLD        = 3'd0,
        AG_CLEAR       = 3'd1,
        AG_K_FIRST     = 3'd2,
        AG_K_STEP      = 3'd3,
        AG_TO_ACT      = 3'd4,
        AG_NEXT_NEURON = 3'd5,
        AG_TO_UPD      = 3'd6,
        AG_UPD_STEP    = 3'd7
    } agen_cmd_e;

    localparam int unsigned VAD_M     = 24;
    localparam int unsigned VAD_N     = 24;
    localparam int unsigned NOISE_M   = 90;
    localparam int unsigned NOISE_N   = 48;
    localparam int unsigned DENOISE_M = 114;
    localparam int unsigned DENOISE_N = 96;

    function automatic op_kind_e state_kind(input state_e s);
        op_kind_e k;
        k = OP_BIAS;
        case (s)
            S_IN:    k = OP_IN;
            S_REC:   k = OP_REC;
            S_ACT:   k = OP_ACT;
            S_UPD:   k = OP_UPD;
            default: k = OP_BIAS;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/gru_addr_gen.sv
// Gate/neuron/operand counters and the multiplier-free weight/bias index adder.
module gru_addr_gen
    import gru_pkg::*;
#(
    parameter int unsigned M  = 24,
    parameter int unsigned N  = 24,
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    cmd_i,
    output logic [1:0]    gate_o,
    output logic [AW-1:0] j_o,
    output logic [AW-1:0] k_o,
    output logic [AW-1:0] waddr_o,
    output logic          last_k_in_c_o,
    output logic          last_k_rec_c_o,
    output logic          last_j_c_o,
    output logic          last_gate_c_o
);

    localparam logic [AW-1:0] STRIDE   = AW'(3 * N);
    localparam logic [AW-1:0] LAST_IN  = AW'(M - 1);
    localparam logic [AW-1:0] LAST_REC = AW'(N - 1);

    logic [1:0]    gate_q, gate_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] base_q, base_d;

    // base tracks gate*N + j; it simply increments per neuron across gate boundaries.
    always_comb begin
        gate_d  = gate_q;
        j_d     = j_q;
        k_d     = k_q;
        waddr_d = waddr_q;
        base_d  = base_q;
        case (cmd_i)
            AG_CLEAR: begin
                gate_d  = 2'd0;
                j_d     = '0;
                k_d     = '0;
                waddr_d = '0;
                base_d  = '0;
            end
            AG_K_FIRST: begin
                k_d     = '0;
                waddr_d = base_q;
            end
            AG_K_STEP: begin
                k_d     = k_q + AW'(1);
                waddr_d = waddr_q + STRIDE;
            end
            AG_TO_ACT: begin
                k_d     = '0;
                waddr_d = '0;
            end
            AG_NEXT_NEURON: begin
                base_d  = base_q + AW'(1);
                waddr_d = base_q + AW'(1);
                if (j_q == LAST_REC) begin
                    j_d    = '0;
                    gate_d = gate_q + 2'd1;
                end else begin
                    j_d = j_q + AW'(1);
                end
            end
            AG_TO_UPD: begin
                j_d     = '0;
                k_d     = '0;
                waddr_d = '0;
            end
            AG_UPD_STEP: begin
                j_d = j_q + AW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q  <= 2'd0;
            j_q     <= '0;
            k_q     <= '0;
            waddr_q <= '0;
            base_q  <= '0;
        end else begin
            gate_q  <= gate_d;
            j_q     <= j_d;
            k_q     <= k_d;
            waddr_q <= waddr_d;
            base_q  <= base_d;
        end
    end

    assign gate_o         = gate_q;
    assign j_o            = j_q;
    assign k_o            = k_q;
    assign waddr_o        = waddr_q;
    assign last_k_in_c_o  = (k_q == LAST_IN);
    assign last_k_rec_c_o = (k_q == LAST_REC);
    assign last_j_c_o     = (j_q == LAST_REC);
    assign last_gate_c_o  = (gate_q == GATE_H);

endmodule

// File: rtl/gru_sched.sv
// GRU layer micro-op sequencer: walks bias/input/recurrent/activation per neuron per gate, then the update pass.
module gru_sched
    import gru_pkg::*;
#(
    parameter int unsigned M  = 24,
    parameter int unsigned N  = 24,
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [2:0]    op_kind,
    output logic [1:0]    op_gate,
    output logic [AW-1:0] op_j,
    output logic [AW-1:0] op_k,
    output logic [AW-1:0] op_waddr,
    output logic          op_clr,
    output logic          op_mul_r,
    output logic          op_act_tanh
);

    state_e    state_q, state_d;
    agen_cmd_e cmd_c;
    logic      hs_c;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      valid_q, valid_d;
    op_kind_e  kind_q, kind_d;
    logic      clr_q, clr_d;
    logic      mul_r_q, mul_r_d;
    logic      tanh_q, tanh_d;
    logic [1:0] gate_w;
    logic      last_k_in_c, last_k_rec_c, last_j_c, last_gate_c;
    logic      gate_h_c;

    gru_addr_gen #(.M(M), .N(N), .AW(AW)) u_addr_gen (
        .clk            (clk),
        .rst            (rst),
        .cmd_i          (cmd_c),
        .gate_o         (gate_w),
        .j_o            (op_j),
        .k_o            (op_k),
        .waddr_o        (op_waddr),
        .last_k_in_c_o  (last_k_in_c),
        .last_k_rec_c_o (last_k_rec_c),
        .last_j_c_o     (last_j_c),
        .last_gate_c_o  (last_gate_c)
    );

    assign hs_c     = valid_q & op_ready;
    assign gate_h_c = (gate_w == GATE_H);

    // Gate never changes on entry to REC/ACT, so the current gate qualifies mul_r/tanh.
    always_comb begin
        state_d = state_q;
        cmd_c   = AG_HOLD;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_BIAS;
                cmd_c   = AG_CLEAR;
            end
            S_BIAS: if (hs_c) begin
                state_d = (M == 0) ? S_REC : S_IN;
                cmd_c   = AG_K_FIRST;
            end
            S_IN: if (hs_c) begin
                if (last_k_in_c) begin
                    state_d = S_REC;
                    cmd_c   = AG_K_FIRST;
                end else begin
                    cmd_c = AG_K_STEP;
                end
            end
            S_REC: if (hs_c) begin
                if (last_k_rec_c) begin
                    state_d = S_ACT;
                    cmd_c   = AG_TO_ACT;
                end else begin
                    cmd_c = AG_K_STEP;
                end
            end
            S_ACT: if (hs_c) begin
                if (last_j_c && last_gate_c) begin
                    state_d = S_UPD;
                    cmd_c   = AG_TO_UPD;
                end else begin
                    state_d = S_BIAS;
                    cmd_c   = AG_NEXT_NEURON;
                end
            end
            S_UPD: if (hs_c) begin
                if (last_j_c) begin
                    state_d = S_FIN;
                end else begin
                    cmd_c = AG_UPD_STEP;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d != S_IDLE) && (state_d != S_FIN);
        busy_d  = valid_d;
        done_d  = (state_d == S_FIN);
        kind_d  = state_kind(state_d);
        clr_d   = (state_d == S_BIAS);
        mul_r_d = (state_d == S_REC) && gate_h_c;
        tanh_d  = (state_d == S_ACT) && gate_h_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            kind_q  <= OP_BIAS;
            clr_q   <= 1'b0;
            mul_r_q <= 1'b0;
            tanh_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            kind_q  <= kind_d;
            clr_q   <= clr_d;
            mul_r_q <= mul_r_d;
            tanh_q  <= tanh_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign op_valid    = valid_q;
    assign op_kind     = kind_q;
    assign op_gate     = gate_w;
    assign op_clr      = clr_q;
    assign op_mul_r    = mul_r_q;
    assign op_act_tanh = tanh_q;

endmodule

// File: tb/tb_gru_sched.sv
// Bench for gru_sched: three layer sizes against an op-list reference model with random backpressure.
module tb_gru_sched;
    import gru_pkg::*;

    localparam int unsigned AW = 16;
    localparam int NC = 3;
    localparam int M0 = 2,  N0 = 1;
    localparam int M1 = 24, N1 = 24;
    localparam int M2 = 90, N2 = 48;

    typedef struct {
        int kind; int gate; int j; int k; int waddr;
        bit clr; bit mulr; bit tanh;
    } exp_t;
    typedef enum int {PH_IDLE, PH_RUN, PH_FIN} ph_e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_s[NC], start_s[NC], ready_s[NC];
    logic          busy_s[NC], done_s[NC], valid_s[NC];
    logic          clr_s[NC], mulr_s[NC], tanh_s[NC];
    logic [2:0]    kind_s[NC];
    logic [1:0]    gate_s[NC];
    logic [AW-1:0] j_s[NC], k_s[NC], wa_s[NC];

    gru_sched #(.M(M0), .N(N0), .AW(AW)) dut0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .op_valid(valid_s[0]), .op_ready(ready_s[0]), .op_kind(kind_s[0]), .op_gate(gate_s[0]),
        .op_j(j_s[0]), .op_k(k_s[0]), .op_waddr(wa_s[0]), .op_clr(clr_s[0]),
        .op_mul_r(mulr_s[0]), .op_act_tanh(tanh_s[0]));
    gru_sched #(.M(M1), .N(N1), .AW(AW)) dut1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .op_valid(valid_s[1]), .op_ready(ready_s[1]), .op_kind(kind_s[1]), .op_gate(gate_s[1]),
        .op_j(j_s[1]), .op_k(k_s[1]), .op_waddr(wa_s[1]), .op_clr(clr_s[1]),
        .op_mul_r(mulr_s[1]), .op_act_tanh(tanh_s[1]));
    gru_sched #(.M(M2), .N(N2), .AW(AW)) dut2 (
        .clk(clk), .rst(rst_s[2]), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .op_valid(valid_s[2]), .op_ready(ready_s[2]), .op_kind(kind_s[2]), .op_gate(gate_s[2]),
        .op_j(j_s[2]), .op_k(k_s[2]), .op_waddr(wa_s[2]), .op_clr(clr_s[2]),
        .op_mul_r(mulr_s[2]), .op_act_tanh(tanh_s[2]));

    exp_t exp_q[NC][$];
    ph_e  ph[NC]        = '{PH_IDLE, PH_IDLE, PH_IDLE};
    int   ptr[NC]       = '{0, 0, 0};
    int   acc[NC]       = '{0, 0, 0};
    int   aborts[NC]    = '{0, 0, 0};
    int   dones_dut[NC] = '{0, 0, 0};
    int   run_cyc[NC]   = '{0, 0, 0};
    bit   all_ready[NC] = '{1'b0, 1'b0, 1'b0};
    bit   chk_rst[NC]   = '{1'b0, 1'b0, 1'b0};
    bit   stall_prev[NC] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] prev_f[NC];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   neg_n = 0;
    bit   pinned = 1'b0;
    bit   finish_req = 1'b0;
    int   timeouts = 0;

    function automatic exp_t mk(input int kind, input int g, input int j, input int k,
                                input int w, input bit clr, input bit mulr, input bit tanh);
        exp_t e;
        e.kind = kind; e.gate = g; e.j = j; e.k = k; e.waddr = w;
        e.clr = clr; e.mulr = mulr; e.tanh = tanh;
        return e;
    endfunction

    // Expected op list, straight from the layer loop nest.
    task automatic build(input int c, input int m, input int n);
        exp_q[c].delete();
        for (int g = 0; g < 3; g++) begin
            for (int j = 0; j < n; j++) begin
                exp_q[c].push_back(mk(int'(OP_BIAS), g, j, 0, g*n + j, 1'b1, 1'b0, 1'b0));
                for (int k = 0; k < m; k++)
                    exp_q[c].push_back(mk(int'(OP_IN), g, j, k, k*3*n + g*n + j, 1'b0, 1'b0, 1'b0));
                for (int k = 0; k < n; k++)
                    exp_q[c].push_back(mk(int'(OP_REC), g, j, k, k*3*n + g*n + j, 1'b0, g == 2, 1'b0));
                exp_q[c].push_back(mk(int'(OP_ACT), g, j, 0, 0, 1'b0, 1'b0, g == 2));
            end
        end
        for (int j = 0; j < n; j++)
            exp_q[c].push_back(mk(int'(OP_UPD), 0, j, 0, 0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cfg%0d t=%0t: got %0d, required %0d", name, c, $time, act, req);
        end
    endtask

    function automatic logic [63:0] flds(input int c);
        return {8'd0, kind_s[c], gate_s[c], j_s[c], k_s[c], wa_s[c], clr_s[c], mulr_s[c], tanh_s[c]};
    endfunction

    // Single compare process: phase model per configuration, sampled on the falling edge.
    always @(negedge clk) begin
        ph_e  nph;
        exp_t e;
        neg_n++;
        if (!pinned) begin
            pinned = 1'b1;
            check("pin_len0", 0, exp_q[0].size(), 16);
            check("pin_in4", 0, exp_q[0][7].waddr, 4);
            check("pin_rec_h_w", 0, exp_q[0][13].waddr, 2);
            check("pin_rec_h_mulr", 0, exp_q[0][13].mulr, 1);
            check("pin_act_h_tanh", 0, exp_q[0][14].tanh, 1);
            check("pin_len1", 1, exp_q[1].size(), 3624);
            check("pin_last_rec1", 1, exp_q[1][3598].waddr, 1727);
            check("pin_r_j5_gate", 1, exp_q[1][1450].gate, 1);
            check("pin_r_j5_j", 1, exp_q[1][1450].j, 5);
            check("pin_len2", 2, exp_q[2].size(), 20208);
            check("pin_last_in2", 2, exp_q[2][20110].waddr, 12959);
            check("pin_last_rec2", 2, exp_q[2][20158].waddr, 6911);
        end
        for (int c = 0; c < NC; c++) begin
            nph = ph[c];
            if (done_s[c] === 1'b1) dones_dut[c]++;
            if (chk_rst[c]) begin
                check("reset_fields", c, flds(c), 64'd0);
                chk_rst[c] = 1'b0;
            end
            if (neg_n > 1) begin
                case (ph[c])
                    PH_IDLE: begin
                        check("idle_valid", c, valid_s[c], 0);
                        check("idle_busy", c, busy_s[c], 0);
                        check("idle_done", c, done_s[c], 0);
                        if (start_s[c] && !rst_s[c]) begin
                            nph = PH_RUN; ptr[c] = 0; acc[c]++;
                            run_cyc[c] = 0; all_ready[c] = 1'b1; stall_prev[c] = 1'b0;
                        end
                    end
                    PH_RUN: begin
                        run_cyc[c]++;
                        check("run_valid", c, valid_s[c], 1);
                        check("run_busy", c, busy_s[c], 1);
                        check("run_done", c, done_s[c], 0);
                        if (stall_prev[c]) check("stall_stable", c, flds(c), prev_f[c]);
                        if (ptr[c] < exp_q[c].size()) begin
                            e = exp_q[c][ptr[c]];
                            check("op_kind", c, kind_s[c], e.kind);
                            if (e.kind != int'(OP_UPD)) check("op_gate", c, gate_s[c], e.gate);
                            check("op_j", c, j_s[c], e.j);
                            if (e.kind == int'(OP_IN) || e.kind == int'(OP_REC)) check("op_k", c, k_s[c], e.k);
                            check("op_waddr", c, wa_s[c], e.waddr);
                            check("op_clr", c, clr_s[c], e.clr);
                            check("op_mul_r", c, mulr_s[c], e.mulr);
                            check("op_act_tanh", c, tanh_s[c], e.tanh);
                        end else begin
                            check("op_overrun", c, ptr[c], exp_q[c].size() - 1);
                        end
                        if (!ready_s[c]) all_ready[c] = 1'b0;
                        stall_prev[c] = !ready_s[c];
                        prev_f[c] = flds(c);
                        if (ready_s[c]) ptr[c]++;
                        if (ptr[c] >= exp_q[c].size()) nph = PH_FIN;
                    end
                    default: begin
                        run_cyc[c]++;
                        check("fin_done", c, done_s[c], 1);
                        check("fin_valid", c, valid_s[c], 0);
                        check("fin_busy", c, busy_s[c], 0);
                        if (all_ready[c]) check("latency", c, run_cyc[c], exp_q[c].size() + 1);
                        nph = PH_IDLE;
                    end
                endcase
            end
            if (rst_s[c]) begin
                if (ph[c] == PH_RUN) aborts[c]++;
                nph = PH_IDLE;
                chk_rst[c] = 1'b1;
                stall_prev[c] = 1'b0;
            end
            ph[c] = nph;
        end
        if (finish_req) begin
            for (int c = 0; c < NC; c++) check("done_count", c, dones_dut[c], acc[c] - aborts[c]);
            check("run_timeouts", 0, timeouts, 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready held high; mode 1: random backpressure with 5-cycle low stretches.
    task automatic run(input int c, input int mode, input int xs, input bit sad, input int rp);
        int cyc = 0;
        int stretch = 0;
        int r;
        ready_s[c] = 1'b1;
        start_s[c] = 1'b1;
        tick();
        start_s[c] = 1'b0;
        while (ph[c] != PH_IDLE && cyc < 60000) begin
            if (mode == 1) begin
                if (stretch > 0) begin
                    ready_s[c] = 1'b0;
                    stretch--;
                end else begin
                    r = $urandom_range(0, 19);
                    if (r == 0) begin
                        ready_s[c] = 1'b0;
                        stretch = 4;
                    end else begin
                        ready_s[c] = (r > 5);
                    end
                end
            end else begin
                ready_s[c] = 1'b1;
            end
            start_s[c] = (cyc == xs) || (sad && ph[c] == PH_FIN);
            rst_s[c]   = (rp >= 0) && (ph[c] == PH_RUN) && (ptr[c] == rp);
            tick();
            cyc++;
        end
        if (ph[c] != PH_IDLE) timeouts++;
        start_s[c] = 1'b0;
        rst_s[c]   = 1'b0;
        ready_s[c] = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            rst_s[c] = 1'b1; start_s[c] = 1'b0; ready_s[c] = 1'b1;
        end
        build(0, M0, N0);
        build(1, M1, N1);
        build(2, M2, N2);
        repeat (3) tick();
        for (int c = 0; c < NC; c++) rst_s[c] = 1'b0;
        repeat (2) tick();

        run(0, 0, -1, 1'b1, -1);
        run(0, 1, 3, 1'b1, -1);
        run(1, 0, 100, 1'b1, -1);
        run(1, 1, 500, 1'b0, -1);
        run(1, 0, -1, 1'b0, 1450);
        run(1, 0, -1, 1'b1, -1);
        run(2, 0, 7, 1'b1, -1);

        finish_req = 1'b1;
        repeat (4) @(posedge clk);
    end

endmodule
